// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline stage register with optional one-entry skid buffer. The main
//   register (M) always drives the outputs. With SKID=1 a second register (S)
//   catches the beat that arrives while M is stalled, so in_ready can come
//   straight from a flop and has no combinational path from out_ready. With
//   SKID=0 only M exists, and in_ready is combinational.
//   Control bits are zeroed whenever an entry is invalid, so downstream logic
//   can use out_ctrl without gating it by out_valid. Payload bits are left
//   alone on a bubble.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   flush                 drop all held entries and the current input beat
//   in_valid/in_ready     upstream handshake
//   in_ctrl, in_data      upstream control fields and payload
//   out_valid/out_ready   downstream handshake
//   out_ctrl, out_data    registered control and payload, taken from M
//   count                 number of held entries (0..2)
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              m_vld_q, m_vld_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_vld_q, s_vld_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              rdy_q, rdy_d;

  logic accept;
  logic consume;
  logic m_free;

  // With a skid slot, in_ready is the registered "S is empty" flag.
  assign in_ready = HAS_SKID ? rdy_q : (out_ready | ~m_vld_q);

  always_comb begin
    accept   = in_valid & in_ready & ~flush;
    consume  = m_vld_q & out_ready;
    m_free   = ~m_vld_q | consume;

    m_vld_d  = m_vld_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_vld_d  = s_vld_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;

    if (flush) begin
      m_vld_d  = 1'b0;
      m_ctrl_d = '0;
      s_vld_d  = 1'b0;
      s_ctrl_d = '0;
    end else if (m_free) begin
      if (s_vld_q) begin
        // The oldest beat is in S, so it moves to M first to keep FIFO order.
        m_vld_d  = 1'b1;
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        s_vld_d  = accept;
        s_ctrl_d = accept ? in_ctrl : '0;
        if (accept) s_data_d = in_data;
      end else begin
        // Straight pass-through; no accept means a bubble with ctrl zeroed
        // and the payload left holding its last value.
        m_vld_d  = accept;
        m_ctrl_d = accept ? in_ctrl : '0;
        if (accept) m_data_d = in_data;
        s_vld_d  = 1'b0;
        s_ctrl_d = '0;
      end
    end else if (accept) begin
      // M is stalled: park the new beat in S.
      s_vld_d  = 1'b1;
      s_ctrl_d = in_ctrl;
      s_data_d = in_data;
    end

    if (!HAS_SKID) begin
      s_vld_d  = 1'b0;
      s_ctrl_d = '0;
      s_data_d = '0;
    end

    rdy_d = ~s_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld_q  <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_vld_q  <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      rdy_q    <= 1'b1;
    end else begin
      m_vld_q  <= m_vld_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_vld_q  <= s_vld_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      rdy_q    <= rdy_d;
    end
  end

  assign out_valid = m_vld_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign count     = {1'b0, m_vld_q} + {1'b0, s_vld_q};

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;

  logic        r1, v1, r0, v0;
  logic [7:0]  c1, c0;
  logic [31:0] d1, d0;
  logic [1:0]  n1, n0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v1), .out_ready(out_ready),
    .out_ctrl(c1), .out_data(d1), .count(n1)
  );

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v0), .out_ready(out_ready),
    .out_ctrl(c0), .out_data(d0), .count(n0)
  );

  // Reference model: each DUT is a FIFO of held beats (capacity 2 or 1).
  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } beat_t;

  beat_t       q1[$];
  beat_t       q0[$];
  logic [31:0] ld1 = '0, ld0 = '0;  // payload shown while empty
  bit          dk1 = 0, dk0 = 0;    // whether that payload is defined

  // Advance one clock edge and move both models by the handshake rules.
  task automatic tick();
    bit a1, a0, k1, k0;
    a1 = in_valid && (q1.size() < 2) && !flush;
    a0 = in_valid && (out_ready || q0.size() == 0) && !flush;
    k1 = (q1.size() > 0) && out_ready;
    k0 = (q0.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      q1.delete(); q0.delete();
      ld1 = '0; ld0 = '0; dk1 = 1; dk0 = 1;
    end else if (flush) begin
      q1.delete(); q0.delete();
      dk1 = 0; dk0 = 0;
    end else begin
      if (k1) begin ld1 = q1[0].d; dk1 = 1; void'(q1.pop_front()); end
      if (k0) begin ld0 = q0[0].d; dk0 = 1; void'(q0.pop_front()); end
      if (a1) q1.push_back({in_ctrl, in_data});
      if (a0) q0.push_back({in_ctrl, in_data});
    end
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; flush = 0; out_ready = 0;
    tick();
    reset = 0;
    n_tests += 6;
    if (v1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", v1); end
    if (c1 !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", c1); end
    if (d1 !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", d1); end
    if (n1 !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", n1); end
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1 got=%0b exp=1", r1); end
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready0 got=%0b exp=1", r0); end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_ctrl = 8'h81; in_data = 32'h10 + i;
      tick();
      n_tests += 5;
      if (v1 !== 1'b1 || d1 !== 32'h10 + i) begin
        n_fail++; $display("FAIL stream_data i=%0d got=%0b/%h exp=1/%h", i, v1, d1, 32'h10 + i);
      end
      if (c1 !== 8'h81) begin n_fail++; $display("FAIL stream_ctrl got=%h exp=81", c1); end
      if (n1 !== 2'd1) begin n_fail++; $display("FAIL stream_count got=%0d exp=1", n1); end
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL stream_ready got=%0b exp=1", r1); end
      if (d0 !== 32'h10 + i) begin n_fail++; $display("FAIL stream_data0 got=%h exp=%h", d0, 32'h10 + i); end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h11; in_data = 32'hA;
    tick();
    in_data = 32'hB; in_ctrl = 8'h22;
    tick();
    in_valid = 0;
    n_tests += 2;
    if (n1 !== 2'd2) begin n_fail++; $display("FAIL bp_count got=%0d exp=2", n1); end
    if (r1 !== 1'b0) begin n_fail++; $display("FAIL bp_ready got=%0b exp=0", r1); end
    out_ready = 1;
    #1;
    n_tests++;
    if (v1 !== 1'b1 || d1 !== 32'hA || c1 !== 8'h11) begin
      n_fail++; $display("FAIL bp_first got=%0b/%h/%h exp=1/a/11", v1, d1, c1);
    end
    tick();
    n_tests++;
    if (v1 !== 1'b1 || d1 !== 32'hB || c1 !== 8'h22) begin
      n_fail++; $display("FAIL bp_second got=%0b/%h/%h exp=1/b/22", v1, d1, c1);
    end
    tick();
    n_tests += 2;
    if (v1 !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0b exp=0", v1); end
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%0b exp=1", r1); end
  endtask

  task automatic test_bubble();
    out_ready = 1; in_valid = 1; in_ctrl = 8'hFF; in_data = 32'h55;
    tick();
    in_valid = 0;
    n_tests++;
    if (v1 !== 1'b1 || c1 !== 8'hFF) begin n_fail++; $display("FAIL bubble_beat got=%0b/%h exp=1/ff", v1, c1); end
    tick();
    n_tests += 2;
    if (v1 !== 1'b0 || c1 !== 8'h00) begin n_fail++; $display("FAIL bubble_ctrl got=%0b/%h exp=0/00", v1, c1); end
    if (d1 !== 32'h55) begin n_fail++; $display("FAIL bubble_hold got=%h exp=55", d1); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_ctrl = 8'h01; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    n_tests++;
    if (n1 !== 2'd2) begin n_fail++; $display("FAIL flush_pre got=%0d exp=2", n1); end
    flush = 1; in_ctrl = 8'h5A; in_data = 32'hDEAD; in_valid = 1;
    tick();
    flush = 0; in_valid = 0;
    n_tests += 3;
    if (v1 !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0b exp=0", v1); end
    if (n1 !== 2'd0 || n0 !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d/%0d exp=0", n1, n0); end
    if (c1 !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl got=%h exp=00", c1); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (v1 !== 1'b0 || v0 !== 1'b0) begin
        n_fail++; $display("FAIL flush_leak got=%0b/%0b data=%h exp=0", v1, v0, d1);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; in_ctrl = 8'h0C; in_data = 32'h31;
    tick();
    in_data = 32'h32;
    tick();
    reset = 1; in_data = 32'h99;
    tick();
    reset = 0;
    n_tests += 2;
    if (v1 !== 1'b0 || c1 !== 8'h00 || d1 !== 32'h0 || n1 !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_out got=%0b/%h/%h/%0d exp=0/00/0/0", v1, c1, d1, n1);
    end
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%0b exp=1", r1); end
    out_ready = 1; in_valid = 1; in_ctrl = 8'h03; in_data = 32'h77;
    tick();
    in_valid = 0;
    n_tests++;
    if (v1 !== 1'b1 || d1 !== 32'h77 || c1 !== 8'h03) begin
      n_fail++; $display("FAIL rstmid_first got=%0b/%h/%h exp=1/77/03", v1, d1, c1);
    end
    tick();
  endtask

  task automatic test_skid0();
    bit pat[6] = '{1, 0, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i]; in_valid = 1; in_ctrl = 8'h40 + 8'(i); in_data = 32'h200 + i;
      #1;
      n_tests++;
      if (r0 !== (out_ready || q0.size() == 0)) begin
        n_fail++; $display("FAIL skid0_ready i=%0d got=%0b exp=%0b", i, r0, (out_ready || q0.size() == 0));
      end
      tick();
      n_tests += 2;
      if (n0 > 2'd1) begin n_fail++; $display("FAIL skid0_count got=%0d exp<=1", n0); end
      if (v0 !== (q0.size() > 0) || (q0.size() > 0 && d0 !== q0[0].d)) begin
        n_fail++; $display("FAIL skid0_beat got=%0b/%h exp=%0b/%h", v0, d0, q0.size() > 0,
                           q0.size() > 0 ? q0[0].d : 32'h0);
      end
    end
    in_valid = 0; out_ready = 1;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0]  ec;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset     = ($urandom_range(0, 149) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 8'($urandom_range(1, 255));
      in_data   = $urandom;
      tick();
      reset = 0; flush = 0;
      n_tests += 2;
      ec = (q1.size() > 0) ? q1[0].c : 8'h00;
      if (v1 !== (q1.size() > 0) || c1 !== ec || n1 !== 2'(q1.size()) || r1 !== (q1.size() < 2) ||
          (q1.size() > 0 && d1 !== q1[0].d) || (q1.size() == 0 && dk1 && d1 !== ld1)) begin
        n_fail++;
        $display("FAIL rand1 cyc=%0d got v=%0b c=%h d=%h n=%0d r=%0b exp v=%0b c=%h n=%0d", cyc,
                 v1, c1, d1, n1, r1, q1.size() > 0, ec, q1.size());
      end
      ec = (q0.size() > 0) ? q0[0].c : 8'h00;
      if (v0 !== (q0.size() > 0) || c0 !== ec || n0 !== 2'(q0.size()) ||
          r0 !== (out_ready || q0.size() == 0) ||
          (q0.size() > 0 && d0 !== q0[0].d) || (q0.size() == 0 && dk0 && d0 !== ld0)) begin
        n_fail++;
        $display("FAIL rand0 cyc=%0d got v=%0b c=%h d=%h n=%0d r=%0b exp v=%0b c=%h n=%0d", cyc,
                 v0, c0, d0, n0, r0, q0.size() > 0, ec, q0.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_skid0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width; payload bits are never cleared by a bubble.
REQ-002 Parameter CTRL_W, default 8: control width (RegWr, MemWr, MemRd, MemtoReg, ...); control bits are forced to 0 on bubble, flush and reset.
REQ-003 Parameter SKID, default 1: 1 = one-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discard all held entries and the current input beat.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control fields.
REQ-010 in_data  input  DATA_W  upstream payload (PC+4, ALU result, store data, register numbers).
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_ready  input  1  downstream accepts a beat.
REQ-013 out_ctrl  output  CTRL_W  registered control; all zeros whenever out_valid=0.
REQ-014 out_data  output  DATA_W  registered payload.
REQ-015 count  output  2  number of held entries (0..2; never exceeds 1 when SKID=0).

Function
REQ-016 The block shall hold state in a main register (M) and, when SKID=1, a skid register (S), each with its own valid bit; out_* shall be driven only from M.
REQ-017 An input beat is accepted iff in_valid & in_ready & !flush; an output beat is consumed iff out_valid & out_ready.
REQ-018 With SKID=1, in_ready shall equal !S.valid and shall be a registered signal, with no combinational path from out_ready.
REQ-019 With SKID=0, in_ready shall equal out_ready | !M.valid.
REQ-020 Latency: an accepted beat shall appear on out_* in the next cycle if M is empty or is consumed in the same cycle.
REQ-021 When M is empty or consumed, M shall load from S if S.valid, otherwise from the accepted input; S shall then load the accepted input if S was the source, else clear.
REQ-022 When M is full, not consumed, and a beat is accepted (SKID=1 only), that beat shall be written into S.
REQ-023 Simultaneous accept and consume with S empty shall pass the new beat into M with no bubble; count shall stay at 1.
REQ-024 Ordering shall be strictly FIFO; beats shall never be dropped or duplicated except by flush.
REQ-025 When M is empty or consumed and nothing is accepted, M.valid shall clear and out_ctrl shall be 0; out_data shall hold its last value.
REQ-026 Flush shall take priority over all other events: next cycle M.valid=S.valid=0, out_ctrl=0 and count=0, and the same-cycle input beat shall be dropped; out_data is don't-care.
REQ-027 count shall equal M.valid + S.valid and shall update in the same edge as the valid bits.

Reset
REQ-028 On reset=1 at a rising edge, M.valid, S.valid, out_valid, out_ctrl, out_data and count shall become 0.
REQ-029 in_ready shall be 1 in the cycle following reset, in both SKID modes.
REQ-030 Reset shall take priority over flush and over handshakes; any beat in flight shall be discarded.

Verification
REQ-031 Stream: out_ready=1, 4 beats data=0x10..0x13, ctrl=0x81 -> out_* matches each beat one cycle later, count stays at 1, in_ready stays 1.
REQ-032 Backpressure, SKID=1: out_ready=0 with beats A=0xA and B=0xB -> count=2, in_ready=0; set out_ready=1 -> outputs A then B on consecutive cycles, in_ready returns 1.
REQ-033 Bubble: one beat ctrl=0xFF, then in_valid=0 -> out_ctrl=0xFF for one cycle, then out_valid=0 and out_ctrl=0x00.
REQ-034 Flush with count=2 and in_valid=1 -> next cycle out_valid=0, count=0, out_ctrl=0; the flushed-cycle input never appears on the output.
REQ-035 Reset mid-stream with count=2 -> next cycle all outputs 0, in_ready=1; the first beat after reset appears with 1-cycle latency.
REQ-036 SKID=0 with out_ready toggling 1,0,1 -> in_ready tracks out_ready|!out_valid combinationally, count never exceeds 1, no beat is lost.
